// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel and window widths plus the slot layout
// of a packed 3x3 window, used by window_3x3_gen and the downstream filter modules.
package img_pkg;

    localparam int PIX_W = 12;
    localparam int WIN_W = 9 * PIX_W;

    // Bit offsets of each neighbour inside a packed window word.
    localparam int OFF_CENTER    = 96;
    localparam int OFF_LEFT      = 84;
    localparam int OFF_RIGHT     = 72;
    localparam int OFF_UP        = 60;
    localparam int OFF_DOWN      = 48;
    localparam int OFF_UPLEFT    = 36;
    localparam int OFF_UPRIGHT   = 24;
    localparam int OFF_DOWNLEFT  = 12;
    localparam int OFF_DOWNRIGHT = 0;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0] window_t;

    function automatic window_t pack_window(
        input pixel_t center,
        input pixel_t left,
        input pixel_t right,
        input pixel_t up,
        input pixel_t down,
        input pixel_t upleft,
        input pixel_t upright,
        input pixel_t downleft,
        input pixel_t downright
    );
        window_t w;
        w = '0;
        w[OFF_CENTER    +: PIX_W] = center;
        w[OFF_LEFT      +: PIX_W] = left;
        w[OFF_RIGHT     +: PIX_W] = right;
        w[OFF_UP        +: PIX_W] = up;
        w[OFF_DOWN      +: PIX_W] = down;
        w[OFF_UPLEFT    +: PIX_W] = upleft;
        w[OFF_UPRIGHT   +: PIX_W] = upright;
        w[OFF_DOWNLEFT  +: PIX_W] = downleft;
        w[OFF_DOWNRIGHT +: PIX_W] = downright;
        return w;
    endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-port line memory: asynchronous read of the addressed entry and a write
// of the same entry on the clock edge, so a read always returns the old contents.
module line_buffer #(
    parameter int DEPTH  = 320,
    parameter int WIDTH  = 12,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    assign rd_data = mem[addr];

    // Contents are deliberately not reset; the window generator gates stale rows.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streams RGB444 pixels into two line buffers and a 3x3 register window, emitting a
// packed window for every interior center. Define WINDOW_COORD_OUT_EN for out_x/out_y.
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [WIN_W-1:0] color_data,
    output logic             window_valid
`ifdef WINDOW_COORD_OUT_EN
    ,
    output logic [9:0]       out_x,
    output logic [9:0]       out_y
`endif
);

    localparam int XW = $clog2(IMG_WIDTH);

    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] px;
    logic [9:0] py;
    logic       emit;
    pixel_t     row1_rd;
    pixel_t     row2_rd;

    // win[row][col]: row 0 is two lines up, col 0 is the oldest column.
    logic [2:0][2:0][PIX_W-1:0] win;
    logic [2:0][2:0][PIX_W-1:0] next_win;

    // sof forces the accepted pixel to (0,0) whatever the counters say.
    assign px   = sof ? 10'd0 : x;
    assign py   = sof ? 10'd0 : y;
    assign emit = pix_valid && (px >= 10'd2) && (py >= 10'd2);

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_row1 (
        .clk     (clk),
        .en      (pix_valid),
        .addr    (px[XW-1:0]),
        .wr_data (pix_in),
        .rd_data (row1_rd)
    );

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_row2 (
        .clk     (clk),
        .en      (pix_valid),
        .addr    (px[XW-1:0]),
        .wr_data (row1_rd),
        .rd_data (row2_rd)
    );

    always_comb begin
        next_win = win;
        for (int r = 0; r < 3; r++) begin
            next_win[r][0] = win[r][1];
            next_win[r][1] = win[r][2];
        end
        next_win[0][2] = row2_rd;
        next_win[1][2] = row1_rd;
        next_win[2][2] = pix_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x            <= '0;
            y            <= '0;
            win          <= '0;
            color_data   <= '0;
            window_valid <= 1'b0;
        end else begin
            window_valid <= emit;
            if (pix_valid) begin
                win <= next_win;
                if (px == 10'(IMG_WIDTH - 1)) begin
                    x <= '0;
                    y <= (py == 10'(IMG_HEIGHT - 1)) ? 10'd0 : py + 10'd1;
                end else begin
                    x <= px + 10'd1;
                    y <= py;
                end
            end
            if (emit) begin
                color_data <= pack_window(next_win[1][1], next_win[1][0], next_win[1][2],
                                          next_win[0][1], next_win[2][1], next_win[0][0],
                                          next_win[0][2], next_win[2][0], next_win[2][2]);
            end
        end
    end

`ifdef WINDOW_COORD_OUT_EN
    // Center sits one column and one row behind the pixel that completes the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_x <= '0;
            out_y <= '0;
        end else if (emit) begin
            out_x <= px - 10'd1;
            out_y <= py - 10'd1;
        end
    end
`endif

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, pixels per line (3..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, lines per frame (3..1024).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pix_in  input  12  RGB444 pixel, R[11:8] G[7:4] B[3:0].
REQ-006 SHALL have port pix_valid  input  1  pix_in accepted this cycle; no backpressure.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid, marks pixel (0,0).
REQ-008 SHALL have port color_data  output  108  packed 3x3 window, registered.
REQ-009 SHALL have port window_valid  output  1  color_data holds a new window this cycle (1-cycle pulse).

Function
REQ-010 SHALL pack color_data: center[107:96], left[95:84], right[83:72], up[71:60], down[59:48], upleft[47:36], upright[35:24], downleft[23:12], downright[11:0].
REQ-011 SHALL track input column x (0..IMG_WIDTH-1) and row y (0..IMG_HEIGHT-1), advancing only on pix_valid.
REQ-012 SHALL wrap x to 0 and increment y after x=IMG_WIDTH-1; after (IMG_WIDTH-1, IMG_HEIGHT-1) wrap to (0,0).
REQ-013 SHALL force the accepted pixel to position (0,0) when sof=1 with pix_valid=1, regardless of counter state (mid-frame resync).
REQ-014 SHALL store the two previous lines in two line buffers of depth IMG_WIDTH, read-before-write at column x.
REQ-015 SHALL maintain a 3x3 register window shifted by one column per accepted pixel; no shift when pix_valid=0.
REQ-016 SHALL emit a window only for interior centers: center (x-1, y-1) with x>=2 and y>=2 of the accepted pixel.
REQ-017 SHALL assert window_valid and update color_data exactly 1 cycle after accepting pixel (cx+1, cy+1) for center (cx, cy).
REQ-018 SHALL emit exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per complete frame.
REQ-019 SHALL hold color_data unchanged while window_valid=0.
REQ-020 SHALL never mix pixels across a line wrap: columns 0 and 1 of each row produce no window.
REQ-021 SHALL treat rows 0 and 1 after sof or after reset as priming rows (no windows), even if line buffers hold stale data.

Reset
REQ-022 SHALL on reset clear color_data to 0, window_valid to 0, x and y to 0, and the 3x3 window registers to 0.
REQ-023 SHALL not reset line-buffer contents; REQ-021 gating makes them don't-care.
REQ-024 SHALL resume on the first pixel after reset release as if it were (0,0), with or without sof.

Configuration
REQ-025 SHALL, when WINDOW_COORD_OUT_EN is defined, add outputs out_x[9:0] and out_y[9:0] giving the center coordinates of color_data, registered alongside it and reset to 0.
REQ-026 SHALL, when WINDOW_COORD_OUT_EN is undefined, omit out_x/out_y and their logic; all other behaviour identical.

Structure
REQ-027 SHALL take PIX_W=12, WIN_W=108 and the nine slot bit offsets from shared package img_pkg, also used by the filter modules.
REQ-028 SHALL instantiate sub-module line_buffer (single-port, read-before-write, parameterised depth and width) twice.
REQ-029 SHALL be 120-400 lines of RTL, no vendor primitives.

Verification (IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = y*16+x)
REQ-030 Stream full frame with sof on first pixel -> first window_valid 1 cycle after pixel (2,2): center 0x011, left 0x010, right 0x012, up 0x001, down 0x021, upleft 0x000, upright 0x002, downleft 0x020, downright 0x022.
REQ-031 Same frame -> exactly 6 windows, centers (1,1),(2,1),(3,1),(1,2),(2,2),(3,2); none after pixels at x=0 or x=1.
REQ-032 Random pix_valid gaps (30% low) -> same 6 windows, same values, color_data stable during gaps.
REQ-033 sof asserted at pixel (3,2) mid-frame, then a full frame -> no window until new (2,2); then 6 correct windows.
REQ-034 reset pulse at input pixel (2,2) of frame 1, then full frame without sof -> outputs 0 during reset, then 6 correct windows.
REQ-035 Build with WINDOW_COORD_OUT_EN -> out_x/out_y match REQ-031 centers on each window_valid; without it -> ports absent, REQ-030 still passes.
